// File: rtl/perf_monitor_pkg.sv
// Shared types and constants for the run/performance monitor.
// Holds the state encoding, read-select width helper and default sizing.
package perf_monitor_pkg;

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StHalted  = 2'd1,
    StTimeout = 2'd2
  } state_e;

  localparam int unsigned DefCntW          = 32;
  localparam int unsigned DefTimeoutCycles = 500000;

  // Select 0 is the cycle counter, 1..num_evt are the event channels.
  function automatic int unsigned sel_width(input int unsigned num_evt);
    return (num_evt == 0) ? 1 : $clog2(num_evt + 1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with sticky overflow flag.
// The increment that would wrap holds the value at max and sets ovf.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q,
  output logic         ovf
);

  logic [W-1:0] q_q, q_d;
  logic         ovf_q, ovf_d;
  logic         at_max;

  assign at_max = &q_q;

  always_comb begin
    q_d   = q_q;
    ovf_d = ovf_q;
    if (clr) begin
      q_d   = '0;
      ovf_d = 1'b0;
    end else if (inc) begin
      if (at_max) begin
        ovf_d = 1'b1;
      end else begin
        q_d = q_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q   <= '0;
      ovf_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      ovf_q <= ovf_d;
    end
  end

  assign q   = q_q;
  assign ovf = ovf_q;

endmodule

// File: rtl/perf_monitor.sv
// Run/performance monitor: cycle and per-channel event counters, halt capture,
// programmable run timeout and a registered counter read port.
module perf_monitor
  import perf_monitor_pkg::*;
#(
  parameter int unsigned CNT_W          = DefCntW,
  parameter int unsigned NUM_EVT        = 4,
  parameter int unsigned RET_W          = 16,
  parameter int unsigned TIMEOUT_CYCLES = DefTimeoutCycles,
  parameter int unsigned SIM_FINISH     = 0,
  localparam int unsigned SEL_W         = sel_width(NUM_EVT)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               run_en,
  input  logic               is_halt,
  input  logic [RET_W-1:0]   ret_val,
  input  logic [NUM_EVT-1:0] evt,
  input  logic [SEL_W-1:0]   rd_sel,
  output logic [CNT_W-1:0]   rd_data,
  output logic               rd_ovf,
  output logic               halted,
  output logic               timed_out,
  output logic               done,
  output logic [RET_W-1:0]   result
);

  state_e             state_q, state_d;
  logic [RET_W-1:0]   result_q, result_d;
  logic [CNT_W-1:0]   rd_data_q, rd_data_d;
  logic               rd_ovf_q, rd_ovf_d;

  logic               count_en;
  logic               timeout_hit;
  logic [CNT_W-1:0]   cyc_cnt;
  logic               cyc_ovf;
  logic [CNT_W-1:0]   evt_cnt [NUM_EVT];
  logic [NUM_EVT-1:0] evt_ovf;

  // Counters advance only while running; clear zeroes them on the same edge.
  assign count_en = (state_q == StRun) && run_en && !clear;

  if (TIMEOUT_CYCLES != 0) begin : g_timeout
    // Compare in 64 bits so a limit wider than the counter never falsely matches.
    assign timeout_hit = (64'(cyc_cnt) == (64'(TIMEOUT_CYCLES) - 64'd1));
  end else begin : g_no_timeout
    assign timeout_hit = 1'b0;
  end

  sat_counter #(
    .W (CNT_W)
  ) u_cyc_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clear),
    .inc   (count_en),
    .q     (cyc_cnt),
    .ovf   (cyc_ovf)
  );

  for (genvar i = 0; i < NUM_EVT; i++) begin : g_evt
    sat_counter #(
      .W (CNT_W)
    ) u_evt_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clear),
      .inc   (count_en && evt[i]),
      .q     (evt_cnt[i]),
      .ovf   (evt_ovf[i])
    );
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    if (clear) begin
      state_d  = StRun;
      result_d = '0;
    end else if ((state_q == StRun) && run_en) begin
      if (is_halt) begin
        state_d  = StHalted;
        result_d = ret_val;
      end else if (timeout_hit) begin
        state_d = StTimeout;
      end
    end
  end

  always_comb begin
    rd_data_d = '0;
    rd_ovf_d  = 1'b0;
    if (rd_sel == '0) begin
      rd_data_d = cyc_cnt;
      rd_ovf_d  = cyc_ovf;
    end
    for (int i = 0; i < NUM_EVT; i++) begin
      if (rd_sel == SEL_W'(i + 1)) begin
        rd_data_d = evt_cnt[i];
        rd_ovf_d  = evt_ovf[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StRun;
      result_q  <= '0;
      rd_data_q <= '0;
      rd_ovf_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      rd_data_q <= rd_data_d;
      rd_ovf_q  <= rd_ovf_d;
    end
  end

  assign rd_data   = rd_data_q;
  assign rd_ovf    = rd_ovf_q;
  assign halted    = (state_q == StHalted);
  assign timed_out = (state_q == StTimeout);
  assign done      = halted || timed_out;
  assign result    = result_q;

`ifndef SYNTHESIS
  if (SIM_FINISH != 0) begin : g_sim_finish
    always_ff @(posedge clk) begin
      if (rst_n && (state_q == StRun) && (state_d == StHalted)) begin
        $display("Finished with %0d", ret_val);
        $finish;
      end else if (rst_n && (state_q == StRun) && (state_d == StTimeout)) begin
        $display("ran for %0d cycles", TIMEOUT_CYCLES);
        $finish;
      end
    end
  end
`endif

endmodule

// File: tb/tb_perf_monitor.sv
// Directed bench for perf_monitor: a 32-bit instance with a 10-cycle timeout
// and a 4-bit instance without timeout for saturation, sharing all inputs.
module tb_perf_monitor;

  logic        clk;
  logic        rst_n;
  logic        clear;
  logic        run_en;
  logic        is_halt;
  logic [15:0] ret_val;
  logic [3:0]  evt;
  logic [2:0]  rd_sel;

  logic [31:0] a_rd_data;
  logic        a_rd_ovf, a_halted, a_timed_out, a_done;
  logic [15:0] a_result;
  logic [3:0]  s_rd_data;
  logic        s_rd_ovf, s_halted, s_timed_out, s_done;
  logic [15:0] s_result;

  int n_cmp = 0;
  int n_bad = 0;

  perf_monitor #(
    .CNT_W          (32),
    .NUM_EVT        (4),
    .RET_W          (16),
    .TIMEOUT_CYCLES (10),
    .SIM_FINISH     (0)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .run_en    (run_en),
    .is_halt   (is_halt),
    .ret_val   (ret_val),
    .evt       (evt),
    .rd_sel    (rd_sel),
    .rd_data   (a_rd_data),
    .rd_ovf    (a_rd_ovf),
    .halted    (a_halted),
    .timed_out (a_timed_out),
    .done      (a_done),
    .result    (a_result)
  );

  perf_monitor #(
    .CNT_W          (4),
    .NUM_EVT        (4),
    .RET_W          (16),
    .TIMEOUT_CYCLES (0),
    .SIM_FINISH     (0)
  ) u_sat (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .run_en    (run_en),
    .is_halt   (is_halt),
    .ret_val   (ret_val),
    .evt       (evt),
    .rd_sel    (rd_sel),
    .rd_data   (s_rd_data),
    .rd_ovf    (s_rd_ovf),
    .halted    (s_halted),
    .timed_out (s_timed_out),
    .done      (s_done),
    .result    (s_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n   = 1'b0;
    clear   = 1'b0;
    run_en  = 1'b0;
    is_halt = 1'b0;
    ret_val = '0;
    evt     = '0;
    rd_sel  = '0;
    #12;
    check_eq("rst_halted", 64'(a_halted), 64'd0);
    check_eq("rst_done", 64'(a_done), 64'd0);
    check_eq("rst_rd_data", 64'(a_rd_data), 64'd0);
    check_eq("rst_result", 64'(a_result), 64'd0);
    rst_n = 1'b1;

    // Halt after 7 run cycles, evt[0] on 3 of them
    run_en = 1'b1;
    for (int i = 0; i < 7; i++) begin
      evt = (i == 1 || i == 3 || i == 5) ? 4'b0001 : 4'b0000;
      step();
    end
    evt = '0;
    check_eq("pre_halt_halted", 64'(a_halted), 64'd0);
    is_halt = 1'b1;
    ret_val = 16'h002A;
    step();
    is_halt = 1'b0;
    check_eq("halt_halted", 64'(a_halted), 64'd1);
    check_eq("halt_done", 64'(a_done), 64'd1);
    check_eq("halt_timed_out", 64'(a_timed_out), 64'd0);
    check_eq("halt_result", 64'(a_result), 64'h2A);
    rd_sel = 3'd0;
    step();
    check_eq("halt_cycles", 64'(a_rd_data), 64'd8);
    rd_sel = 3'd1;
    step();
    check_eq("halt_evt0", 64'(a_rd_data), 64'd3);

    // Clear from HALTED
    clear = 1'b1;
    step();
    clear = 1'b0;
    check_eq("clr_halted", 64'(a_halted), 64'd0);
    check_eq("clr_done", 64'(a_done), 64'd0);
    check_eq("clr_result", 64'(a_result), 64'd0);
    rd_sel = 3'd0;
    step();
    check_eq("clr_cycles", 64'(a_rd_data), 64'd0);
    check_eq("clr_ovf", 64'(a_rd_ovf), 64'd0);

    // Timeout: cycle_count is 1 here, 9 more edges reach 10
    repeat (8) step();
    check_eq("to_pre", 64'(a_timed_out), 64'd0);
    step();
    check_eq("to_timed_out", 64'(a_timed_out), 64'd1);
    check_eq("to_done", 64'(a_done), 64'd1);
    check_eq("to_halted", 64'(a_halted), 64'd0);
    evt = 4'hF;
    repeat (3) step();
    evt = '0;
    rd_sel = 3'd0;
    step();
    check_eq("to_cycles", 64'(a_rd_data), 64'd10);
    rd_sel = 3'd1;
    step();
    check_eq("to_evt0_frozen", 64'(a_rd_data), 64'd0);

    // Halt on the same edge as timeout wins
    clear = 1'b1;
    step();
    clear = 1'b0;
    repeat (9) step();
    is_halt = 1'b1;
    ret_val = 16'h1234;
    step();
    is_halt = 1'b0;
    check_eq("race_halted", 64'(a_halted), 64'd1);
    check_eq("race_timed_out", 64'(a_timed_out), 64'd0);
    check_eq("race_result", 64'(a_result), 64'h1234);
    rd_sel = 3'd0;
    step();
    check_eq("race_cycles", 64'(a_rd_data), 64'd10);

    // run_en low pauses counting and ignores halt
    clear = 1'b1;
    step();
    clear = 1'b0;
    evt = 4'b0001;
    repeat (3) step();
    run_en = 1'b0;
    evt = 4'hF;
    ret_val = 16'hBEEF;
    for (int i = 0; i < 5; i++) begin
      is_halt = (i % 2 == 0);
      step();
    end
    is_halt = 1'b0;
    evt = '0;
    check_eq("pause_halted", 64'(a_halted), 64'd0);
    check_eq("pause_done", 64'(a_done), 64'd0);
    check_eq("pause_result", 64'(a_result), 64'd0);
    rd_sel = 3'd0;
    step();
    check_eq("pause_cycles", 64'(a_rd_data), 64'd3);
    run_en = 1'b1;
    repeat (2) step();
    run_en = 1'b0;
    rd_sel = 3'd0;
    step();
    check_eq("resume_cycles", 64'(a_rd_data), 64'd5);
    rd_sel = 3'd1;
    step();
    check_eq("resume_evt0", 64'(a_rd_data), 64'd3);
    rd_sel = 3'd2;
    step();
    check_eq("pause_evt1", 64'(a_rd_data), 64'd0);
    rd_sel = 3'd5;
    step();
    check_eq("badsel_data", 64'(a_rd_data), 64'd0);
    check_eq("badsel_ovf", 64'(a_rd_ovf), 64'd0);

    // Saturation on the 4-bit instance
    clear = 1'b1;
    step();
    clear = 1'b0;
    run_en = 1'b1;
    evt = 4'b0010;
    repeat (20) step();
    evt = '0;
    run_en = 1'b0;
    rd_sel = 3'd2;
    step();
    check_eq("sat_evt1", 64'(s_rd_data), 64'd15);
    check_eq("sat_evt1_ovf", 64'(s_rd_ovf), 64'd1);
    check_eq("sat_done", 64'(s_done), 64'd0);
    check_eq("to_evt1", 64'(a_rd_data), 64'd10);
    check_eq("to_evt1_ovf", 64'(a_rd_ovf), 64'd0);
    rd_sel = 3'd0;
    step();
    check_eq("sat_cycles", 64'(s_rd_data), 64'd15);
    check_eq("sat_cycles_ovf", 64'(s_rd_ovf), 64'd1);
    rd_sel = 3'd1;
    step();
    check_eq("sat_evt0", 64'(s_rd_data), 64'd0);
    check_eq("sat_evt0_ovf", 64'(s_rd_ovf), 64'd0);

    // Asynchronous reset mid-cycle
    rd_sel = 3'd0;
    step();
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("arst_rd_data", 64'(s_rd_data), 64'd0);
    check_eq("arst_rd_ovf", 64'(s_rd_ovf), 64'd0);
    check_eq("arst_timed_out", 64'(a_timed_out), 64'd0);
    check_eq("arst_done", 64'(a_done), 64'd0);
    rst_n = 1'b1;
    step();
    check_eq("arst_cycles", 64'(a_rd_data), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
